// File: rtl/max_pool_engine_pkg.sv
// Shared definitions for the max-pooling engine: FP16 width, pooling geometry,
// AlexNet pool-layer constants, FSM state encodings and small helpers.
package max_pool_engine_pkg;

    localparam int FP16_W = 16;
    localparam int DATA_W = FP16_W;
    localparam int ADDR_W = 19;
    localparam int POOL_K = 3;
    localparam int POOL_S = 2;
    localparam int SIZE_W = 8;
    localparam int CH_W   = 9;

    // AlexNet pool-layer input geometry (map side / channel count)
    localparam int POOL1_IN_SIZE  = 55;
    localparam int POOL1_CHANNELS = 96;
    localparam int POOL2_IN_SIZE  = 27;
    localparam int POOL2_CHANNELS = 256;
    localparam int POOL5_IN_SIZE  = 13;
    localparam int POOL5_CHANNELS = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } poolState_t;

    // Maps an FP16 value onto an unsigned key whose ordering follows the
    // numeric ordering, with -0 sitting just below +0.
    function automatic logic [FP16_W-1:0] fp16Key(input logic [FP16_W-1:0] v);
        return v[FP16_W-1] ? ~v : {1'b1, v[FP16_W-2:0]};
    endfunction

    // Multiplies an address-width value by a small elaboration-time constant
    // using shifted adds only.
    function automatic logic [ADDR_W-1:0] mulConst(input logic [ADDR_W-1:0] x, input int k);
        logic [ADDR_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (((k >> i) & 1) != 0) begin
                sum = sum + (x << i);
            end
        end
        return sum;
    endfunction

    // Output map side for a given input side.
    function automatic logic [SIZE_W-1:0] outSizeOf(input logic [SIZE_W-1:0] inSize);
        return ((inSize - SIZE_W'(POOL_K)) / SIZE_W'(POOL_S)) + SIZE_W'(1);
    endfunction

endpackage

// File: rtl/max_pool_engine_if.sv
// Control, configuration and layer-RAM bus of the max-pooling engine.
// The engine connects through the slave modport; the controller/RAM side
// uses the master modport.
interface max_pool_engine_if;
    import max_pool_engine_pkg::*;

    logic              poolStart;
    logic [SIZE_W-1:0] cfgInSize;
    logic [CH_W-1:0]   cfgChannels;
    logic [ADDR_W-1:0] cfgInBase;
    logic [ADDR_W-1:0] cfgOutBase;
    logic              layerReadEn;
    logic [ADDR_W-1:0] layerReadAddr;
    logic [DATA_W-1:0] layerReadData;
    logic              layerWriteEn;
    logic [ADDR_W-1:0] writeLayerAddr;
    logic [DATA_W-1:0] writeLayerData;
    logic              poolStatus;

    modport slave (
        input  poolStart, cfgInSize, cfgChannels, cfgInBase, cfgOutBase, layerReadData,
        output layerReadEn, layerReadAddr, layerWriteEn, writeLayerAddr, writeLayerData, poolStatus
    );

    modport master (
        output poolStart, cfgInSize, cfgChannels, cfgInBase, cfgOutBase, layerReadData,
        input  layerReadEn, layerReadAddr, layerWriteEn, writeLayerAddr, writeLayerData, poolStatus
    );

endinterface

// File: rtl/max_pool_engine_fp16_max.sv
// fp16_max: combinational FP16 comparator based on ordered keys.
// Shared with the fully-connected block.
module fp16_max
    import max_pool_engine_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic              aGtB,
    output logic [FP16_W-1:0] maxVal
);

    // Strict greater-than on ordered keys; ties keep b.
    always_comb begin
        aGtB   = fp16Key(a) > fp16Key(b);
        maxVal = aGtB ? a : b;
    end

endmodule

// File: rtl/max_pool_engine.sv
// max_pool_engine: KxK stride-S FP16 max pooling over a feature map held in
// layer RAM, one window at a time (READ x K*K, DRAIN, WRITE).
// Optional macro POOL_RELU_EN: writes 0 for windows whose max is negative.
module max_pool_engine
    import max_pool_engine_pkg::*;
(
    input logic              clk,
    input logic              poolRst,
    max_pool_engine_if.slave bus
);

    localparam logic [SIZE_W-1:0] K_LAST      = SIZE_W'(POOL_K - 1);
    localparam logic [ADDR_W-1:0] STRIDE_STEP = ADDR_W'(POOL_S);

    poolState_t        state;
    logic [SIZE_W-1:0] outSize;
    logic [SIZE_W-1:0] kx;
    logic [SIZE_W-1:0] ky;
    logic [SIZE_W-1:0] ox;
    logic [SIZE_W-1:0] oy;
    logic [CH_W-1:0]   channels;
    logic [CH_W-1:0]   chanIdx;
    logic [ADDR_W-1:0] inStep;
    logic [ADDR_W-1:0] sIn;
    logic [ADDR_W-1:0] kIn;
    logic [ADDR_W-1:0] rowBase;
    logic [ADDR_W-1:0] winBase;
    logic [ADDR_W-1:0] kRow;
    logic [ADDR_W-1:0] outPtr;
    logic [DATA_W-1:0] acc;
    logic              sampleValid;
    logic              sampleFirst;

    logic              readEn;
    logic [ADDR_W-1:0] readAddr;
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              status;

    logic              sampleGt;
    logic [DATA_W-1:0] candMax;
    logic [DATA_W-1:0] accNext;
    logic [DATA_W-1:0] writeValue;
    logic [ADDR_W-1:0] startStep;
    logic [ADDR_W-1:0] rowNext;
    logic [ADDR_W-1:0] winNext;
    logic              lastCol;
    logic              lastRow;
    logic              lastChan;

    assign startStep = {{(ADDR_W - SIZE_W){1'b0}}, bus.cfgInSize};

    fp16_max uMax (
        .a      (bus.layerReadData),
        .b      (acc),
        .aGtB   (sampleGt),
        .maxVal (candMax)
    );

    // Next accumulator value, value to write, and start address of the next window.
    always_comb begin
        accNext = (sampleFirst || sampleGt) ? bus.layerReadData : candMax;
`ifdef POOL_RELU_EN
        writeValue = accNext[DATA_W-1] ? '0 : accNext;
`else
        writeValue = accNext;
`endif
        lastCol  = (ox == outSize - 1'b1);
        lastRow  = (oy == outSize - 1'b1);
        lastChan = (chanIdx == channels - 1'b1);
        rowNext  = lastRow ? rowBase + kIn : rowBase + sIn;
        winNext  = lastCol ? rowNext : winBase + STRIDE_STEP;
    end

    // Window sequencer: address walk, max accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (poolRst) begin
            state       <= IDLE;
            outSize     <= '0;
            kx          <= '0;
            ky          <= '0;
            ox          <= '0;
            oy          <= '0;
            channels    <= '0;
            chanIdx     <= '0;
            inStep      <= '0;
            sIn         <= '0;
            kIn         <= '0;
            rowBase     <= '0;
            winBase     <= '0;
            kRow        <= '0;
            outPtr      <= '0;
            acc         <= '0;
            sampleValid <= 1'b0;
            sampleFirst <= 1'b0;
            readEn      <= 1'b0;
            readAddr    <= '0;
            writeEn     <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            status      <= 1'b0;
        end else begin
            sampleValid <= readEn;
            sampleFirst <= readEn && (kx == '0) && (ky == '0);
            if (sampleValid) begin
                acc <= accNext;
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.poolStart) begin
                        outSize  <= outSizeOf(bus.cfgInSize);
                        channels <= bus.cfgChannels;
                        inStep   <= startStep;
                        sIn      <= mulConst(startStep, POOL_S);
                        kIn      <= mulConst(startStep, POOL_K);
                        rowBase  <= bus.cfgInBase;
                        winBase  <= bus.cfgInBase;
                        kRow     <= bus.cfgInBase;
                        readAddr <= bus.cfgInBase;
                        outPtr   <= bus.cfgOutBase;
                        kx       <= '0;
                        ky       <= '0;
                        ox       <= '0;
                        oy       <= '0;
                        chanIdx  <= '0;
                        if (bus.cfgChannels == '0) begin
                            state  <= DONE;
                            status <= 1'b1;
                        end else begin
                            state  <= READ;
                            status <= 1'b0;
                            readEn <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (kx != K_LAST) begin
                        kx       <= kx + 1'b1;
                        readAddr <= readAddr + 1'b1;
                    end else if (ky != K_LAST) begin
                        kx       <= '0;
                        ky       <= ky + 1'b1;
                        kRow     <= kRow + inStep;
                        readAddr <= kRow + inStep;
                    end else begin
                        kx     <= '0;
                        ky     <= '0;
                        readEn <= 1'b0;
                        state  <= DRAIN;
                    end
                end

                DRAIN: begin
                    writeEn   <= 1'b1;
                    writeAddr <= outPtr;
                    writeData <= writeValue;
                    outPtr    <= outPtr + 1'b1;
                    state     <= WRITE;
                end

                WRITE: begin
                    writeEn <= 1'b0;
                    if (lastCol && lastRow && lastChan) begin
                        state  <= DONE;
                        status <= 1'b1;
                    end else begin
                        if (lastCol) begin
                            ox      <= '0;
                            rowBase <= rowNext;
                            if (lastRow) begin
                                oy      <= '0;
                                chanIdx <= chanIdx + 1'b1;
                            end else begin
                                oy <= oy + 1'b1;
                            end
                        end else begin
                            ox <= ox + 1'b1;
                        end
                        winBase  <= winNext;
                        kRow     <= winNext;
                        readAddr <= winNext;
                        readEn   <= 1'b1;
                        state    <= READ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.layerReadEn    = readEn;
    assign bus.layerReadAddr  = readAddr;
    assign bus.layerWriteEn   = writeEn;
    assign bus.writeLayerAddr = writeAddr;
    assign bus.writeLayerData = writeData;
    assign bus.poolStatus     = status;

endmodule
